memwb_stage_pipe: RTL and testbench

MEMWB_STAGE_PIPE -- requirements
Module: memwb_stage_pipe

---
 rtl/memwb_stage_pipe.sv | 93 +++++++++
 tb/tb_memwb_stage_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage_pipe.sv
// memwb_stage_pipe: MEM-to-WB pipeline register with valid/ready handshake, flush and retire counter.
// Define MEMWB_SKID_EN for a two-entry skid buffer whose mem_ready comes straight from a register.
module memwb_stage_pipe #(
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst_n,
    input  logic                 flush,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic                 mem_wreg,
    input  logic [PAYLOAD_W-1:0] mem_payload,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_wreg,
    output logic [PAYLOAD_W-1:0] wb_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     retire_cnt
);
    logic                 main_valid, main_wreg, main_valid_d;
    logic [PAYLOAD_W-1:0] main_payload;
    logic                 accept, retire, load_main;

    assign accept     = mem_valid & mem_ready & ~flush;
    assign retire     = main_valid & wb_ready;
    assign load_main  = ~main_valid | retire;
    assign wb_valid   = main_valid;
    assign wb_wreg    = main_valid & main_wreg;
    assign wb_payload = main_valid ? main_payload : '0;

    // A retire during a flush cycle is still a completed handshake.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end

`ifdef MEMWB_SKID_EN
    logic                 skid_valid, skid_wreg, skid_valid_d;
    logic [PAYLOAD_W-1:0] skid_payload;

    assign mem_ready = ~skid_valid;

    always_comb begin
        main_valid_d = ~flush & (load_main ? (skid_valid | accept) : 1'b1);
        skid_valid_d = ~flush & ~load_main & (skid_valid | accept);
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            occupancy    <= 2'd0;
            main_wreg    <= 1'b0;
            main_payload <= '0;
            skid_wreg    <= 1'b0;
            skid_payload <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            occupancy  <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
            // Skid holds the older entry, so it has priority when main reloads.
            if (load_main) begin
                main_wreg    <= skid_valid ? skid_wreg : mem_wreg;
                main_payload <= skid_valid ? skid_payload : mem_payload;
            end else if (accept) begin
                skid_wreg    <= mem_wreg;
                skid_payload <= mem_payload;
            end
        end
    end
`else
    assign mem_ready = ~main_valid | wb_ready;

    always_comb main_valid_d = ~flush & (load_main ? accept : 1'b1);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            main_valid   <= 1'b0;
            occupancy    <= 2'd0;
            main_wreg    <= 1'b0;
            main_payload <= '0;
        end else begin
            main_valid <= main_valid_d;
            occupancy  <= {1'b0, main_valid_d};
            if (load_main) begin
                main_wreg    <= mem_wreg;
                main_payload <= mem_payload;
            end
        end
    end
`endif
endmodule

// File: tb/tb_memwb_stage_pipe.sv
// tb_memwb_stage_pipe: scoreboard bench; a FIFO of accepted entries is the reference for the stage.
// Mode-dependent acceptance follows MEMWB_SKID_EN when the bench is built with it.
module tb_memwb_stage_pipe;
    localparam int PW = 128;
    localparam int CW = 8;
`ifdef MEMWB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic          w;
        logic [PW-1:0] p;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic          mem_wreg = 1'b0;
    logic [PW-1:0] mem_payload = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic          wb_wreg;
    logic [PW-1:0] wb_payload;
    logic [1:0]    occupancy;
    logic [CW-1:0] retire_cnt;

    ent_t          q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_cmp = 0;
    int            n_fail = 0;

    memwb_stage_pipe #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n(rst_n),
        .flush(flush),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_wreg(mem_wreg),
        .mem_payload(mem_payload),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_wreg(wb_wreg),
        .wb_payload(wb_payload),
        .occupancy(occupancy),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the head of the FIFO is what WB must see; a handshake pops it.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            chk("wb_valid", PW'(wb_valid), PW'(q.size() != 0));
            chk("occupancy", PW'(occupancy), PW'(q.size()));
            chk("retire_cnt", PW'(retire_cnt), PW'(exp_cnt));
            if (q.size() != 0) begin
                chk("wb_payload", wb_payload, q[0].p);
                chk("wb_wreg", PW'(wb_wreg), PW'(q[0].w));
                if (wb_ready) begin
                    void'(q.pop_front());
                    exp_cnt = exp_cnt + 1'b1;
                end
            end else begin
                chk("wb_payload_idle", wb_payload, '0);
                chk("wb_wreg_idle", PW'(wb_wreg), '0);
            end
        end
    end

    // Driver: one cycle of stimulus; an accepted entry is pushed, a flush empties the FIFO.
    task automatic cycle(input logic v, input logic w, input logic [PW-1:0] p, input logic r, input logic f);
        int   qs;
        logic er;
        @(negedge clk);
        mem_valid   = v;
        mem_wreg    = w;
        mem_payload = p;
        wb_ready    = r;
        flush       = f;
        qs = q.size();
        er = SKID ? (qs < 2) : (qs == 0 || r);
        #2;
        chk("mem_ready", PW'(mem_ready), PW'(er));
        if (f) q.delete();
        else if (v && er) q.push_back('{w: w, p: p});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_valid = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b0;
        #3;
        chk("rst_wb_valid", PW'(wb_valid), '0);
        chk("rst_wb_wreg", PW'(wb_wreg), '0);
        chk("rst_wb_payload", wb_payload, '0);
        chk("rst_occupancy", PW'(occupancy), '0);
        chk("rst_retire_cnt", PW'(retire_cnt), '0);
        chk("rst_mem_ready", PW'(mem_ready), PW'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] a5;
        logic [PW-1:0] rp;
        a5 = {16{8'hA5}};
        #3;
        chk("init_wb_valid", PW'(wb_valid), '0);
        chk("init_occupancy", PW'(occupancy), '0);
        chk("init_retire_cnt", PW'(retire_cnt), '0);
        chk("init_mem_ready", PW'(mem_ready), PW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer with latency 1.
        cycle(1'b1, 1'b1, a5, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Back-to-back entries against a stalled WB, then drain in order.
        cycle(1'b1, 1'b0, PW'(128'h10), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, PW'(128'h11), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, PW'(128'h12), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, PW'(128'h12), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, PW'(128'h12 + i), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Fill, then flush with an input present and WB stalled.
        cycle(1'b1, 1'b1, PW'(128'h20), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, PW'(128'h21), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, PW'(128'h22), 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with a retire.
        cycle(1'b1, 1'b0, PW'(128'h30), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, PW'(128'h31), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Sustained throughput long enough to wrap the retire counter.
        for (int i = 0; i < 270; i++) cycle(1'b1, i[0], PW'(i) << 64, 1'b1, 1'b0);

        // Reset in the middle of a transfer, then a fresh transfer.
        cycle(1'b1, 1'b1, PW'(128'h40), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, PW'(128'h41), 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 1'b1, PW'(128'h50), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom % 4) != 0, 1'($urandom), rp,
                  (i % 64) < 48 ? ($urandom % 3) != 0 : ($urandom % 5) == 0,
                  ($urandom % 25) == 0);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
